// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types and defaults for the matrix-multiply operand schedulers
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STREAM,
    DRAIN,
    DONE
  } sched_state_t;

  localparam int LOG2_N1 = 2;

  // Array pipeline depth plus margin; every operand scheduler waits this long.
  function automatic int drain_cyc_default(input int n1, input int n2);
    return n1 + n2 + 2;
  endfunction

endpackage

// File: rtl/tile_beat_cnt.sv
// rtl/tile_beat_cnt.sv - nested col/row beat counter for one tile job
module tile_beat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] col_last,
  input  logic [W-1:0] row_last,
  output logic         last_beat
);

  logic [W-1:0] col_q, col_d;
  logic [W-1:0] row_q, row_d;
  logic         col_wrap;

  always_comb begin
    col_wrap = (col_q == col_last);
    col_d    = col_q;
    row_d    = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + W'(1);
      end else begin
        col_d = col_q + W'(1);
      end
    end
  end

  assign last_beat = en && col_wrap && (row_q == row_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/mm_tile_sched.sv
// rtl/mm_tile_sched.sv - job sequencer: validate, clear readers, stream M1*M3 beats, drain
module mm_tile_sched
  import mm_pkg::*;
#(
  parameter int N1           = 1 << LOG2_N1,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int DRAIN_CYC    = drain_cyc_default(N1, N2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    rd_clr,
  output logic                    valid_D,
  output logic [MATRIXSIZE_W-1:0] M1dN1,
  output logic [MATRIXSIZE_W-1:0] M3_q
);

  localparam int          L2N1       = $clog2(N1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

  sched_state_t            state_q, state_d;
  logic [MATRIXSIZE_W-1:0] cfg_m1_q, cfg_m1_d;
  logic [MATRIXSIZE_W-1:0] cfg_m3_q, cfg_m3_d;
  logic [MATRIXSIZE_W-1:0] m1dn1_q, m1dn1_d;
  logic [15:0]             drain_q, drain_d;
  logic                    err_q, err_d;
  logic                    job_bad;
  logic                    last_beat;

  // M1 must split evenly across the array rows.
  assign job_bad = (M1 == '0) || (M3 == '0) || (M1[L2N1-1:0] != '0);

  always_comb begin
    state_d  = state_q;
    cfg_m1_d = cfg_m1_q;
    cfg_m3_d = cfg_m3_q;
    m1dn1_d  = m1dn1_q;
    drain_d  = drain_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (job_bad) begin
            err_d = 1'b1;
          end else begin
            cfg_m1_d = M1;
            cfg_m3_d = M3;
            m1dn1_d  = M1 >> L2N1;
            state_d  = INIT;
          end
        end
      end
      INIT: begin
        drain_d = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cfg_m1_q <= '0;
      cfg_m3_q <= '0;
      m1dn1_q  <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_m1_q <= cfg_m1_d;
      cfg_m3_q <= cfg_m3_d;
      m1dn1_q  <= m1dn1_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign rd_clr  = (state_q == INIT);
  assign valid_D = (state_q == STREAM) && !stall;
  assign M1dN1   = m1dn1_q;
  assign M3_q    = cfg_m3_q;

  tile_beat_cnt #(
    .W(MATRIXSIZE_W)
  ) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (rd_clr),
    .en       (valid_D),
    .col_last (cfg_m3_q - MATRIXSIZE_W'(1)),
    .row_last (cfg_m1_q - MATRIXSIZE_W'(1)),
    .last_beat(last_beat)
  );

endmodule

// File: tb/tb_mm_tile_sched.sv
// tb/tb_mm_tile_sched.sv - self-checking bench for mm_tile_sched
module tb_mm_tile_sched;

  localparam int N1    = 4;
  localparam int N2    = 4;
  localparam int W     = 16;
  localparam int DRAIN = 10;

  logic         clk = 1'b0;
  logic         rst, start, stall;
  logic [W-1:0] m1, m3;
  logic         busy, done, err, rd_clr, valid_d;
  logic [W-1:0] m1dn1, m3_q;

  int errors = 0;
  int checks = 0;
  bit stall_pat[512];

  typedef struct {
    int m1;
    int m3;
    int smode;
    bit mid_start;
    bit done_start;
    bit exp_err;
    int exp_beats;
    int exp_done;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mm_tile_sched #(
    .N1(N1), .N2(N2), .MATRIXSIZE_W(W), .DRAIN_CYC(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .M1(m1), .M3(m3), .stall(stall),
    .busy(busy), .done(done), .err(err), .rd_clr(rd_clr), .valid_D(valid_d),
    .M1dN1(m1dn1), .M3_q(m3_q)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle of the last beat: beats land on non-stalled cycles from cycle 2 on.
  function automatic int model_last(input int total);
    int b = 0;
    int c = 2;
    while (b < total && c < 511) begin
      if (!stall_pat[c]) b++;
      c++;
    end
    return c - 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_rd_clr"}, int'(rd_clr), 0);
    check({tag, "_valid"}, int'(valid_d), 0);
    check({tag, "_m1dn1"}, int'(m1dn1), 0);
    check({tag, "_m3q"}, int'(m3_q), 0);
  endtask

  task automatic run_job(input int m1v, input int m3v, input bit mid_start,
                         input bit done_start, input bit exp_err,
                         input int exp_beats, input int exp_done, input string name);
    int last, ncyc, beats, vmis, rdclr_cnt, rdclr_first, done_cnt, done_first;
    int err_cnt, err_first, busy_cnt, busy_mis, cfg_mis;
    bit ev;
    last = exp_err ? 0 : model_last(m1v * m3v);
    ncyc = exp_err ? 4 : exp_done + 3;
    beats = 0; vmis = 0; rdclr_cnt = 0; rdclr_first = -1; done_cnt = 0;
    done_first = -1; err_cnt = 0; err_first = -1; busy_cnt = 0; busy_mis = 0; cfg_mis = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = (c == 0) || (mid_start && c == 4) || (done_start && c == exp_done);
      stall = stall_pat[c];
      // Any later start carries a different, legal job that must not be taken.
      m1 = (c == 0) ? W'(m1v) : W'(16);
      m3 = (c == 0) ? W'(m3v) : W'(7);
      #1;
      ev = (c >= 2) && (c <= last) && !stall_pat[c];
      if (valid_d) beats++;
      if (!exp_err && valid_d != ev) vmis++;
      if (rd_clr) begin rdclr_cnt++; if (rdclr_first < 0) rdclr_first = c; end
      if (done) begin done_cnt++; if (done_first < 0) done_first = c; end
      if (err) begin err_cnt++; if (err_first < 0) err_first = c; end
      if (busy) busy_cnt++;
      if (!exp_err && busy != (c >= 1 && c <= exp_done)) busy_mis++;
      if (!exp_err && c >= 1 && c <= exp_done &&
          (int'(m1dn1) != m1v / N1 || int'(m3_q) != m3v)) cfg_mis++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (exp_err) begin
      check({name, "_err_cycle"}, err_first, 1);
      check({name, "_err_cnt"}, err_cnt, 1);
      check({name, "_busy_cnt"}, busy_cnt, 0);
      check({name, "_beats"}, beats, 0);
      check({name, "_rdclr_cnt"}, rdclr_cnt, 0);
    end else begin
      check({name, "_rdclr_cycle"}, rdclr_first, 1);
      check({name, "_rdclr_cnt"}, rdclr_cnt, 1);
      check({name, "_beats"}, beats, exp_beats);
      check({name, "_valid_mis"}, vmis, 0);
      check({name, "_done_cycle"}, done_first, exp_done);
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_busy_mis"}, busy_mis, 0);
      check({name, "_cfg_mis"}, cfg_mis, 0);
      check({name, "_err_cnt"}, err_cnt, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; m1 = '0; m3 = '0;
    vecs[0] = '{8, 3, 0, 1'b0, 1'b0, 1'b0, 24, 36};
    vecs[1] = '{4, 1, 0, 1'b0, 1'b0, 1'b0, 4, 16};
    vecs[2] = '{8, 3, 1, 1'b0, 1'b0, 1'b0, 24, 41};
    vecs[3] = '{6, 3, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{0, 3, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[5] = '{8, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[6] = '{8, 3, 0, 1'b1, 1'b0, 1'b0, 24, 36};
    vecs[7] = '{4, 2, 0, 1'b0, 1'b1, 1'b0, 8, 20};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 512; k++) stall_pat[k] = (vecs[i].smode == 1) && k >= 10 && k < 15;
      run_job(vecs[i].m1, vecs[i].m3, vecs[i].mid_start, vecs[i].done_start,
              vecs[i].exp_err, vecs[i].exp_beats, vecs[i].exp_done, $sformatf("vec%0d", i));
    end

    // Reset mid-job, then confirm the scheduler is idle and reusable.
    begin
      int late_busy = 0;
      int late_done = 0;
      for (int c = 0; c <= 12; c++) begin
        @(negedge clk);
        start = (c == 0);
        m1 = W'(8);
        m3 = W'(3);
        rst = (c == 12);
      end
      start = 1'b0;
      @(negedge clk);
      #1;
      check_reset_outputs("abort");
      rst = 1'b0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        #1;
        if (busy) late_busy++;
        if (done) late_done++;
      end
      check("abort_late_busy", late_busy, 0);
      check("abort_late_done", late_done, 0);
      for (int k = 0; k < 512; k++) stall_pat[k] = 1'b0;
      run_job(8, 3, 1'b0, 1'b0, 1'b0, 24, 36, "after_abort");
    end

    for (int j = 0; j < 10; j++) begin
      int rm1, rm3, last;
      bit bad;
      if ($urandom_range(0, 3) == 0) begin
        rm1 = $urandom_range(0, 12);
        rm3 = $urandom_range(0, 3);
      end else begin
        rm1 = N1 * $urandom_range(1, 3);
        rm3 = $urandom_range(1, 4);
      end
      bad = (rm1 == 0) || (rm3 == 0) || (rm1 % N1 != 0);
      for (int k = 0; k < 512; k++) stall_pat[k] = ($urandom_range(0, 2) == 0);
      last = bad ? 0 : model_last(rm1 * rm3);
      run_job(rm1, rm3, 1'($urandom_range(0, 1)), 1'b0, bad,
              bad ? 0 : rm1 * rm3, bad ? 0 : last + 1 + DRAIN, $sformatf("rand%0d", j));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
